// File: rtl/phy_pkg.sv
// Shared PHY link definitions used by both the transmit (phy_tx) and receive (phy_rx) ends.
package phy_pkg;
  localparam logic [7:0] PHY_COMMA          = 8'hBC;
  localparam int         PHY_SYNC_BYTES_DEF = 4;

  typedef enum logic {SYNC, ACTIVE} phy_tx_state_t;
endpackage

// File: rtl/phy_tx_serial_if.sv
// Byte-side and serial-side signals of the two-lane PHY transmitter.
// PHY_TX_BYTE_CNT_EN adds the per-lane consumed-byte counters.
interface phy_tx_serial_if;
  logic [7:0] data_in_0, data_in_1;
  logic       valid_in_0, valid_in_1;
  logic       ready, active;
  logic       out_0, out_1;
`ifdef PHY_TX_BYTE_CNT_EN
  logic [15:0] tx_byte_cnt_0, tx_byte_cnt_1;

  modport master (output data_in_0, data_in_1, valid_in_0, valid_in_1,
                  input  ready, active, out_0, out_1, tx_byte_cnt_0, tx_byte_cnt_1);
  modport slave  (input  data_in_0, data_in_1, valid_in_0, valid_in_1,
                  output ready, active, out_0, out_1, tx_byte_cnt_0, tx_byte_cnt_1);
`else
  modport master (output data_in_0, data_in_1, valid_in_0, valid_in_1,
                  input  ready, active, out_0, out_1);
  modport slave  (input  data_in_0, data_in_1, valid_in_0, valid_in_1,
                  output ready, active, out_0, out_1);
`endif
endinterface

// File: rtl/phy_tx_lane.sv
// One serial lane: byte/comma mux, MSB-first shift register and registered out bit.
// PHY_TX_BYTE_CNT_EN adds a saturating count of data bytes taken by this lane.
module phy_tx_lane
  import phy_pkg::*;
#(
  parameter logic [7:0] COMMA = PHY_COMMA
) (
  input  logic        clk_8f,
  input  logic        clr,
  input  logic        load,
  input  logic        send,
  input  logic [7:0]  data,
  output logic        out
`ifdef PHY_TX_BYTE_CNT_EN
  ,
  output logic [15:0] byte_cnt
`endif
);
  logic [7:0] shreg, byte_mux;

  assign byte_mux = send ? data : COMMA;

  // MSB leaves on the load edge itself so consecutive bytes have no gap.
  always_ff @(posedge clk_8f) begin
    if (clr) begin
      out   <= 1'b0;
      shreg <= '0;
    end else if (load) begin
      out   <= byte_mux[7];
      shreg <= {byte_mux[6:0], 1'b0};
    end else begin
      out   <= shreg[7];
      shreg <= {shreg[6:0], 1'b0};
    end
  end

`ifdef PHY_TX_BYTE_CNT_EN
  always_ff @(posedge clk_8f) begin
    if (clr)                                   byte_cnt <= '0;
    else if (load && send && byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
  end
`endif
endmodule

// File: rtl/phy_tx_serial.sv
// Two-lane parallel-to-serial PHY transmitter: BC preamble after (re)start, then data or BC fill.
// Build with PHY_TX_BYTE_CNT_EN to get per-lane consumed-byte counters.
module phy_tx_serial
  import phy_pkg::*;
#(
  parameter int         SYNC_BYTES = PHY_SYNC_BYTES_DEF,
  parameter logic [7:0] COMMA      = PHY_COMMA
) (
  input  logic            clk_8f,
  input  logic            reset_L,
  input  logic            enable,
  phy_tx_serial_if.slave  tx
);
  localparam int NUM_LANES = 2;

  phy_tx_state_t                 state;
  logic [2:0]                    cnt;
  logic [3:0]                    bc_cnt;
  logic                          run, clr, load, active_q;
  logic [NUM_LANES-1:0][7:0]     lane_data;
  logic [NUM_LANES-1:0]          lane_vld, lane_out;
`ifdef PHY_TX_BYTE_CNT_EN
  logic [NUM_LANES-1:0][15:0]    lane_cnt;
`endif

  assign run       = reset_L && enable;
  assign clr       = !run;
  assign load      = run && (cnt == 3'd7);
  assign lane_data = {tx.data_in_1, tx.data_in_0};
  assign lane_vld  = {tx.valid_in_1, tx.valid_in_0};

  assign tx.ready  = load && (state == ACTIVE);
  assign tx.active = active_q;
  assign tx.out_0  = lane_out[0];
  assign tx.out_1  = lane_out[1];
`ifdef PHY_TX_BYTE_CNT_EN
  assign tx.tx_byte_cnt_0 = lane_cnt[0];
  assign tx.tx_byte_cnt_1 = lane_cnt[1];
`endif

  // cnt parks at 7 while idle so the first enabled edge is a load edge.
  always_ff @(posedge clk_8f) begin
    if (!run) begin
      cnt      <= 3'd7;
      bc_cnt   <= '0;
      state    <= SYNC;
      active_q <= 1'b0;
    end else begin
      cnt <= cnt + 3'd1;
      if (load && state == SYNC) begin
        if (bc_cnt == 4'(SYNC_BYTES - 1)) begin
          state    <= ACTIVE;
          active_q <= 1'b1;
          bc_cnt   <= '0;
        end else begin
          bc_cnt <= bc_cnt + 4'd1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    phy_tx_lane #(.COMMA(COMMA)) u_lane (
      .clk_8f   (clk_8f),
      .clr      (clr),
      .load     (load),
      .send     ((state == ACTIVE) && lane_vld[i]),
      .data     (lane_data[i]),
      .out      (lane_out[i])
`ifdef PHY_TX_BYTE_CNT_EN
      ,
      .byte_cnt (lane_cnt[i])
`endif
    );
  end
endmodule

// File: tb/tb_phy_tx_serial.sv
// Directed bench for phy_tx_serial: expected serial bits are queued when a slot is driven
// and compared bit by bit on each falling clock edge.
module tb_phy_tx_serial;
  import phy_pkg::*;

  logic clk_8f  = 1'b0;
  logic reset_L = 1'b0;
  logic enable  = 1'b0;

  phy_tx_serial_if tx();

  phy_tx_serial dut (
    .clk_8f  (clk_8f),
    .reset_L (reset_L),
    .enable  (enable),
    .tx      (tx)
  );

  always #5 clk_8f = ~clk_8f;

  int checks = 0;
  int errors = 0;
  int e      = 0;
  bit mon_en = 1'b0;
  bit q0[$];
  bit q1[$];
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;

  task automatic chk1(string tag, logic obs, logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s e=%0d observed=%0b expected=%0b", tag, e, obs, expv);
    end
  endtask

  task automatic chk16(string tag, logic [15:0] obs, logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s e=%0d observed=%0d expected=%0d", tag, e, obs, expv);
    end
  endtask

  task automatic push_byte(logic [7:0] b0, logic [7:0] b1);
    for (int i = 7; i >= 0; i--) begin
      q0.push_back(b0[i]);
      q1.push_back(b1[i]);
    end
  endtask

  // Sample the current bit cycle on the falling edge, then move past the next rising edge.
  task automatic tick();
    @(negedge clk_8f);
    if (mon_en) begin
      if (q0.size() == 0 || q1.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_underflow e=%0d observed=empty expected=bit", e);
      end else begin
        chk1("out_0", tx.out_0, q0.pop_front());
        chk1("out_1", tx.out_1, q1.pop_front());
      end
    end
    @(posedge clk_8f);
    #1;
    e++;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  // Called just before the edge that becomes E0; returns in the ready cycle before E32.
  task automatic preamble();
    push_byte(PHY_COMMA, PHY_COMMA);
    push_byte(PHY_COMMA, PHY_COMMA);
    push_byte(PHY_COMMA, PHY_COMMA);
    push_byte(PHY_COMMA, PHY_COMMA);
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    tick();
    e = 0;
    ticks(23);
    chk1("active_before_e24", tx.active, 1'b0);
    tick();
    chk1("active_after_e24", tx.active, 1'b1);
    ticks(6);
    chk1("ready_e30", tx.ready, 1'b0);
    tick();
  endtask

  task automatic start_link();
    mon_en  = 1'b0;
    reset_L = 1'b0;
    enable  = 1'b1;
    ticks(2);
    chk1("rst_out_0", tx.out_0, 1'b0);
    chk1("rst_out_1", tx.out_1, 1'b0);
    chk1("rst_active", tx.active, 1'b0);
    chk1("rst_ready", tx.ready, 1'b0);
`ifdef PHY_TX_BYTE_CNT_EN
    chk16("rst_cnt_0", tx.tx_byte_cnt_0, 16'd0);
    chk16("rst_cnt_1", tx.tx_byte_cnt_1, 16'd0);
`endif
    reset_L = 1'b1;
    push_byte(PHY_COMMA, PHY_COMMA);
    push_byte(PHY_COMMA, PHY_COMMA);
    push_byte(PHY_COMMA, PHY_COMMA);
    push_byte(PHY_COMMA, PHY_COMMA);
    tick();
    mon_en = 1'b1;
    e = 0;
    ticks(23);
    chk1("active_before_e24", tx.active, 1'b0);
    tick();
    chk1("active_after_e24", tx.active, 1'b1);
    ticks(6);
    chk1("ready_e30", tx.ready, 1'b0);
    tick();
  endtask

  // Entered and left in a ready cycle.
  task automatic slot(bit v0, logic [7:0] d0, bit v1, logic [7:0] d1);
    chk1("ready_slot", tx.ready, 1'b1);
    tx.valid_in_0 = v0;
    tx.data_in_0  = d0;
    tx.valid_in_1 = v1;
    tx.data_in_1  = d1;
    push_byte(v0 ? d0 : PHY_COMMA, v1 ? d1 : PHY_COMMA);
    if (v0) exp_cnt0++;
    if (v1) exp_cnt1++;
    tick();
    tx.valid_in_0 = 1'b0;
    tx.valid_in_1 = 1'b0;
    chk1("ready_after_load", tx.ready, 1'b0);
    ticks(7);
  endtask

  // Valid rises mid-byte and is held; it must be taken once, at the next load edge.
  task automatic mid_valid();
    chk1("ready_slot", tx.ready, 1'b1);
    push_byte(PHY_COMMA, PHY_COMMA);
    ticks(4);
    tx.valid_in_0 = 1'b1;
    tx.data_in_0  = 8'h5A;
    chk1("ready_cnt3", tx.ready, 1'b0);
    ticks(4);
    chk1("ready_mid_valid", tx.ready, 1'b1);
    push_byte(8'h5A, PHY_COMMA);
    exp_cnt0++;
    tick();
    tx.valid_in_0 = 1'b0;
    ticks(7);
  endtask

  // Abort a data byte at cnt==4 by enable or a 1-cycle reset, then require a fresh preamble.
  task automatic abort(bit use_reset);
    logic [7:0] a0, a1;
    a0 = 8'h96;
    a1 = 8'h3C;
    chk1("ready_slot", tx.ready, 1'b1);
    tx.valid_in_0 = 1'b1;
    tx.data_in_0  = a0;
    tx.valid_in_1 = 1'b1;
    tx.data_in_1  = a1;
    for (int i = 7; i >= 3; i--) begin
      q0.push_back(a0[i]);
      q1.push_back(a1[i]);
    end
    tick();
    tx.valid_in_0 = 1'b0;
    tx.valid_in_1 = 1'b0;
    ticks(4);
    if (use_reset) reset_L = 1'b0;
    else           enable  = 1'b0;
    tick();
    q0.push_back(1'b0);
    q1.push_back(1'b0);
    chk1("abort_active", tx.active, 1'b0);
    chk1("abort_ready", tx.ready, 1'b0);
`ifdef PHY_TX_BYTE_CNT_EN
    chk16("abort_cnt_0", tx.tx_byte_cnt_0, 16'd0);
    chk16("abort_cnt_1", tx.tx_byte_cnt_1, 16'd0);
`endif
    if (!use_reset) begin
      tick();
      q0.push_back(1'b0);
      q1.push_back(1'b0);
    end
    reset_L = 1'b1;
    enable  = 1'b1;
    preamble();
  endtask

  initial begin
    tx.data_in_0  = 8'h00;
    tx.data_in_1  = 8'h00;
    tx.valid_in_0 = 1'b0;
    tx.valid_in_1 = 1'b0;

    start_link();
    slot(1'b0, 8'h00, 1'b0, 8'h00);
    slot(1'b0, 8'h00, 1'b0, 8'h00);
    slot(1'b1, 8'hFF, 1'b1, 8'h00);
    slot(1'b1, 8'hEE, 1'b1, 8'hEE);
    slot(1'b1, 8'hDD, 1'b1, 8'hDD);
    slot(1'b1, 8'hAA, 1'b0, 8'h55);
    mid_valid();
    slot(1'b0, 8'h00, 1'b0, 8'h00);
`ifdef PHY_TX_BYTE_CNT_EN
    chk16("cnt_0_run1", tx.tx_byte_cnt_0, 16'(exp_cnt0));
    chk16("cnt_1_run1", tx.tx_byte_cnt_1, 16'(exp_cnt1));
`endif

    abort(1'b0);
    slot(1'b1, 8'h11, 1'b1, 8'h22);
    slot(1'b1, 8'h33, 1'b1, 8'h44);
    slot(1'b1, 8'hC3, 1'b0, 8'h00);
    slot(1'b1, PHY_COMMA, 1'b0, 8'h00);
    slot(1'b1, 8'h7E, 1'b0, 8'h00);
`ifdef PHY_TX_BYTE_CNT_EN
    chk16("cnt_0_five", tx.tx_byte_cnt_0, 16'd5);
    chk16("cnt_1_two", tx.tx_byte_cnt_1, 16'd2);
`endif

    abort(1'b1);
    slot(1'b0, 8'h00, 1'b1, 8'h81);
    slot(1'b0, 8'h00, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
